ysyx_25030093_arbiter: RTL and testbench

YSYX_25030093_ARBITER -- requirements
Module: ysyx_25030093_arbiter

---
 rtl/ysyx_25030093_arbiter_pkg.sv | 17 +
 rtl/ysyx_25030093_arbiter_if.sv | 33 +++
 rtl/ysyx_25030093_arbiter.sv | 151 +++++++++++++++
 tb/tb_ysyx_25030093_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030093_arbiter_pkg.sv
// Shared types and constants for the two-master / one-slave bus arbiter.
package ysyx_25030093_arb_pkg;

  localparam int unsigned STRB_W = 8;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_M0 = 2'd1,
    RD_M1 = 2'd2,
    WR_M1 = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/ysyx_25030093_arbiter_if.sv
// AXI-lite style read/write channel bundle; master drives requests, slave drives responses.
interface ysyx_25030093_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic [AW-1:0]                           araddr;
  logic                                    arvalid;
  logic                                    arready;
  logic [DW-1:0]                           rdata;
  logic                                    rvalid;
  logic                                    rready;
  logic [AW-1:0]                           awaddr;
  logic                                    awvalid;
  logic                                    awready;
  logic [DW-1:0]                           wdata;
  logic [ysyx_25030093_arb_pkg::STRB_W-1:0] wstrb;
  logic                                    wvalid;
  logic                                    wready;
  logic                                    bvalid;
  logic                                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );

endinterface

// File: rtl/ysyx_25030093_arbiter.sv
// Arbiter between IFU (m0, read-only) and LSU (m1) onto one shared slave port.
// One transaction in flight at a time; writes have priority, read ties alternate.
// Optional macro ARB_PERF_CNT_EN adds grant/conflict counters as extra output ports.
module ysyx_25030093_arbiter
  import ysyx_25030093_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_25030093_arbiter_if.slave  m0,
  ysyx_25030093_arbiter_if.slave  m1,
  ysyx_25030093_arbiter_if.master s
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]      perf_m0_gnt,
  output logic [PERF_W-1:0]      perf_m1_rd_gnt,
  output logic [PERF_W-1:0]      perf_m1_wr_gnt,
  output logic [PERF_W-1:0]      perf_conflict
`endif
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       wr_req_c;
  logic       rd_tie_c;

  assign wr_req_c = m1.awvalid & m1.wvalid;
  assign rd_tie_c = m0.arvalid & m1.arvalid;

  // State and last-grant registers; reset favours M0 on the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= M1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Arbitration, completion detection and channel routing
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;

    s.araddr   = AW'(0);
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = AW'(0);
    s.awvalid  = 1'b0;
    s.wdata    = DW'(0);
    s.wstrb    = STRB_W'(0);
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;

    m0.arready = 1'b0;
    m0.rdata   = DW'(0);
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;

    m1.arready = 1'b0;
    m1.rdata   = DW'(0);
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        // A write needs both address and data present before it is granted
        if (wr_req_c) begin
          state_d = WR_M1;
        end else if (rd_tie_c) begin
          state_d = (last_gnt_q == M1) ? RD_M0 : RD_M1;
        end else if (m0.arvalid) begin
          state_d = RD_M0;
        end else if (m1.arvalid) begin
          state_d = RD_M1;
        end
      end
      RD_M0: begin
        s.araddr   = m0.araddr;
        s.arvalid  = m0.arvalid;
        s.rready   = m0.rready;
        m0.arready = s.arready;
        m0.rdata   = s.rdata;
        m0.rvalid  = s.rvalid;
        if (s.rvalid && m0.rready) begin
          state_d    = IDLE;
          last_gnt_d = M0;
        end
      end
      RD_M1: begin
        s.araddr   = m1.araddr;
        s.arvalid  = m1.arvalid;
        s.rready   = m1.rready;
        m1.arready = s.arready;
        m1.rdata   = s.rdata;
        m1.rvalid  = s.rvalid;
        if (s.rvalid && m1.rready) begin
          state_d    = IDLE;
          last_gnt_d = M1;
        end
      end
      WR_M1: begin
        s.awaddr   = m1.awaddr;
        s.awvalid  = m1.awvalid;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid;
        s.bready   = m1.bready;
        m1.awready = s.awready;
        m1.wready  = s.wready;
        m1.bvalid  = s.bvalid;
        if (s.bvalid && m1.bready) begin
          state_d    = IDLE;
          last_gnt_d = M1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic grant_c;
  logic conflict_c;

  assign grant_c    = (state_q == IDLE) && (state_d != IDLE);
  assign conflict_c = (state_q == IDLE) && m0.arvalid && (m1.arvalid || wr_req_c);

  // Wrapping grant and conflict counters, updated on the grant edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_m0_gnt    <= PERF_W'(0);
      perf_m1_rd_gnt <= PERF_W'(0);
      perf_m1_wr_gnt <= PERF_W'(0);
      perf_conflict  <= PERF_W'(0);
    end else begin
      if (grant_c && state_d == RD_M0) perf_m0_gnt    <= perf_m0_gnt + PERF_W'(1);
      if (grant_c && state_d == RD_M1) perf_m1_rd_gnt <= perf_m1_rd_gnt + PERF_W'(1);
      if (grant_c && state_d == WR_M1) perf_m1_wr_gnt <= perf_m1_wr_gnt + PERF_W'(1);
      if (conflict_c)                  perf_conflict  <= perf_conflict + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25030093_arbiter.sv
// Bench for ysyx_25030093_arbiter: directed scenarios plus randomized traffic
// compared against a pending-request / round-robin model.
`timescale 1ns/1ps
module tb_ysyx_25030093_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ysyx_25030093_arbiter_if #(.AW(AW), .DW(DW)) m0 ();
  ysyx_25030093_arbiter_if #(.AW(AW), .DW(DW)) m1 ();
  ysyx_25030093_arbiter_if #(.AW(AW), .DW(DW)) s ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_m0_gnt, perf_m1_rd_gnt, perf_m1_wr_gnt, perf_conflict;
`endif

  ysyx_25030093_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0),
    .m1  (m1),
    .s   (s)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_m0_gnt    (perf_m0_gnt),
    .perf_m1_rd_gnt (perf_m1_rd_gnt),
    .perf_m1_wr_gnt (perf_m1_wr_gnt),
    .perf_conflict  (perf_conflict)
`endif
  );

  // Every DUT output, buses folded to "any bit set"
  function automatic logic [20:0] dut_out();
    return {|s.araddr, s.arvalid, s.rready, |s.awaddr, s.awvalid, |s.wdata, |s.wstrb,
            s.wvalid, s.bready,
            m0.arready, |m0.rdata, m0.rvalid, m0.awready, m0.wready, m0.bvalid,
            m1.arready, |m1.rdata, m1.rvalid, m1.awready, m1.wready, m1.bvalid};
  endfunction

  task automatic clear_inputs();
    m0.araddr = '0; m0.arvalid = 0; m0.rready = 1; m0.awaddr = '0; m0.awvalid = 0;
    m0.wdata = '0; m0.wstrb = '0; m0.wvalid = 0; m0.bready = 1;
    m1.araddr = '0; m1.arvalid = 0; m1.rready = 1; m1.awaddr = '0; m1.awvalid = 0;
    m1.wdata = '0; m1.wstrb = '0; m1.wvalid = 0; m1.bready = 1;
    s.arready = 0; s.rdata = '0; s.rvalid = 0; s.awready = 0; s.wready = 0; s.bvalid = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  // Slave responder plus master-side valid dropping; reports what the masters saw
  task automatic serve(input bit gnt, input bit is_wr, input int dly_a, input int dly_w,
                       input int dly_r, input logic [DW-1:0] rd,
                       output logic [DW-1:0] got, output int n_rv, output int n_bv,
                       output int n_aw, output bit leak, output bit tmo);
    bit a_done, w_done, ha, hw, hr, h0, h1a, h1aw, h1w;
    int resp_at;
    a_done = 0; w_done = !is_wr; resp_at = 0;
    got = '0; n_rv = 0; n_bv = 0; n_aw = 0; leak = 0; tmo = 1;
    for (int c = 0; c < 64; c++) begin
      s.arready = !is_wr && !a_done && (c >= dly_a);
      s.awready = is_wr && !a_done && (c >= dly_a);
      s.wready  = is_wr && !w_done && (c >= dly_w);
      s.rvalid  = !is_wr && a_done && (c >= resp_at);
      s.bvalid  = is_wr && a_done && w_done && (c >= resp_at);
      s.rdata   = s.rvalid ? rd : '0;
      #1;
      if (!gnt) begin
        if (m0.rvalid) begin got = m0.rdata; n_rv++; end
        leak |= m1.arready | m1.rvalid | m1.awready | m1.wready | m1.bvalid;
      end else begin
        if (m1.rvalid) begin got = m1.rdata; n_rv++; end
        leak |= m0.arready | m0.rvalid;
      end
      leak |= m0.awready | m0.wready | m0.bvalid;
      if (m1.bvalid) n_bv++;
      if (s.awvalid) n_aw++;
      ha   = (s.arvalid & s.arready) | (s.awvalid & s.awready);
      hw   = s.wvalid & s.wready;
      hr   = (s.rvalid & s.rready) | (s.bvalid & s.bready);
      h0   = m0.arvalid & m0.arready;
      h1a  = m1.arvalid & m1.arready;
      h1aw = m1.awvalid & m1.awready;
      h1w  = m1.wvalid & m1.wready;
      @(posedge clk); @(negedge clk);
      if (h0)   m0.arvalid = 0;
      if (h1a)  m1.arvalid = 0;
      if (h1aw) m1.awvalid = 0;
      if (h1w)  m1.wvalid = 0;
      if (ha) a_done = 1;
      if (hw) w_done = 1;
      if ((ha || hw) && a_done && w_done) resp_at = c + 1 + dly_r;
      if (hr) begin tmo = 0; break; end
    end
    s.arready = 0; s.awready = 0; s.wready = 0; s.rvalid = 0; s.bvalid = 0; s.rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    m0.arvalid = 1; m1.arvalid = 1; m1.awvalid = 1; m1.wvalid = 1;
    s.rvalid = 1; s.bvalid = 1; s.arready = 1; s.rdata = 32'hffff_ffff;
    @(negedge clk); @(negedge clk); #1;
    n_chk++; if (dut_out() !== 21'd0) $display("FAIL reset_hold: outputs=%h exp 0", dut_out()); else n_pass++;
    clear_inputs(); rst = 0;
    @(negedge clk); #1;
    n_chk++; if (dut_out() !== 21'd0) $display("FAIL reset_idle: outputs=%h exp 0", dut_out()); else n_pass++;
  endtask

  task automatic test_m0_read();
    logic [DW-1:0] got; int nrv, nbv, naw; bit leak, tmo;
    @(negedge clk); m0.araddr = 32'h8000_0000; m0.arvalid = 1; #1;
    n_chk++; if (s.arvalid !== 1'b0) $display("FAIL m0_lat0: s_arvalid=%b exp 0", s.arvalid); else n_pass++;
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if ({s.arvalid, s.araddr} !== {1'b1, 32'h8000_0000})
      $display("FAIL m0_lat1: s_arvalid=%b s_araddr=%h exp 1/80000000", s.arvalid, s.araddr); else n_pass++;
    serve(0, 0, 1, 0, 1, 32'h1234_5678, got, nrv, nbv, naw, leak, tmo);
    n_chk++; if ({tmo, leak, got} !== {2'b00, 32'h1234_5678} || nrv != 1)
      $display("FAIL m0_rdata: got=%h nrv=%0d leak=%b tmo=%b exp 12345678/1/0/0", got, nrv, leak, tmo); else n_pass++;
    #1;
    n_chk++; if (dut_out() !== 21'd0) $display("FAIL m0_back_idle: outputs=%h exp 0", dut_out()); else n_pass++;
  endtask

  task automatic test_tie();
    logic [DW-1:0] got; int nrv, nbv, naw; bit leak, tmo;
    logic [AW-1:0] a0, a1; logic [DW-1:0] d0, d1;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      a0 = 32'h8000_0100 + AW'(r); a1 = 32'h9000_0200 + AW'(r);
      d0 = $urandom; d1 = $urandom;
      m0.araddr = a0; m0.arvalid = 1; m1.araddr = a1; m1.arvalid = 1;
      @(posedge clk); @(negedge clk); #1;
      n_chk++; if ({s.arvalid, s.araddr} !== {1'b1, a0})
        $display("FAIL tie_m0_first r%0d: s_araddr=%h exp %h", r, s.araddr, a0); else n_pass++;
      serve(0, 0, $urandom_range(0, 2), 0, $urandom_range(0, 2), d0, got, nrv, nbv, naw, leak, tmo);
      n_chk++; if ({tmo, leak, got} !== {2'b00, d0} || nrv != 1)
        $display("FAIL tie_m0_data r%0d: got=%h nrv=%0d leak=%b tmo=%b exp %h", r, got, nrv, leak, tmo, d0); else n_pass++;
      #1;
      n_chk++; if (s.arvalid !== 1'b0) $display("FAIL tie_gap r%0d: s_arvalid=%b exp 0", r, s.arvalid); else n_pass++;
      @(posedge clk); @(negedge clk); #1;
      n_chk++; if ({s.arvalid, s.araddr} !== {1'b1, a1})
        $display("FAIL tie_m1_second r%0d: s_araddr=%h exp %h", r, s.araddr, a1); else n_pass++;
      serve(1, 0, $urandom_range(0, 2), 0, $urandom_range(0, 2), d1, got, nrv, nbv, naw, leak, tmo);
      n_chk++; if ({tmo, leak, got} !== {2'b00, d1} || nrv != 1)
        $display("FAIL tie_m1_data r%0d: got=%h nrv=%0d leak=%b tmo=%b exp %h", r, got, nrv, leak, tmo, d1); else n_pass++;
    end
`ifdef ARB_PERF_CNT_EN
    n_chk++; if (perf_m0_gnt !== 32'd2 || perf_m1_rd_gnt !== 32'd2 || perf_m1_wr_gnt !== 32'd0 || perf_conflict < 32'd2)
      $display("FAIL perf_cnt: m0=%0d m1rd=%0d m1wr=%0d conf=%0d exp 2/2/0/>=2",
               perf_m0_gnt, perf_m1_rd_gnt, perf_m1_wr_gnt, perf_conflict); else n_pass++;
`endif
  endtask

  task automatic test_write_prio();
    logic [DW-1:0] got; int nrv, nbv, naw; bit leak, tmo;
    @(negedge clk);
    m0.araddr = 32'h8000_0040; m0.arvalid = 1;
    m1.awaddr = 32'ha000_03f8; m1.awvalid = 1; m1.wdata = 32'h41; m1.wstrb = 8'h01; m1.wvalid = 1;
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if ({s.awvalid, s.awaddr, s.wvalid, s.wdata, s.wstrb, s.arvalid} !== {1'b1, 32'ha000_03f8, 1'b1, 32'h41, 8'h01, 1'b0})
      $display("FAIL wr_grant: awv=%b awaddr=%h wv=%b wdata=%h wstrb=%h arv=%b exp 1/a00003f8/1/41/01/0",
               s.awvalid, s.awaddr, s.wvalid, s.wdata, s.wstrb, s.arvalid); else n_pass++;
    serve(1, 1, 0, 0, 1, '0, got, nrv, nbv, naw, leak, tmo);
    n_chk++; if (tmo || leak || nbv != 1 || nrv != 0)
      $display("FAIL wr_resp: bvalid_cnt=%0d rvalid_cnt=%0d leak=%b tmo=%b exp 1/0/0/0", nbv, nrv, leak, tmo); else n_pass++;
    #1; @(posedge clk); @(negedge clk); #1;
    n_chk++; if ({s.arvalid, s.araddr} !== {1'b1, 32'h8000_0040})
      $display("FAIL wr_then_m0: s_arvalid=%b s_araddr=%h exp 1/80000040", s.arvalid, s.araddr); else n_pass++;
    serve(0, 0, 0, 0, 0, 32'hcafe_f00d, got, nrv, nbv, naw, leak, tmo);
    n_chk++; if ({tmo, leak, got} !== {2'b00, 32'hcafe_f00d})
      $display("FAIL wr_then_m0_data: got=%h leak=%b tmo=%b exp cafef00d", got, leak, tmo); else n_pass++;
  endtask

  task automatic test_aw_delay();
    logic [DW-1:0] got; int nrv, nbv, naw; bit leak, tmo, seen;
    @(negedge clk); m1.awaddr = 32'ha000_0010; m1.awvalid = 1; seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk); #1;
      seen |= s.awvalid | s.arvalid;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL aw_only_idle: s_awvalid seen=%b exp 0", seen); else n_pass++;
    m1.wdata = 32'h5a5a_0001; m1.wstrb = 8'h0f; m1.wvalid = 1;
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if (s.awvalid !== 1'b1) $display("FAIL aw_w_grant: s_awvalid=%b exp 1", s.awvalid); else n_pass++;
    serve(1, 1, 3, 0, 0, '0, got, nrv, nbv, naw, leak, tmo);
    n_chk++; if (tmo || leak || nbv != 1 || naw != 4)
      $display("FAIL aw_delay: awvalid_cycles=%0d bvalid_cnt=%0d leak=%b tmo=%b exp 4/1/0/0", naw, nbv, leak, tmo); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] got; int nrv, nbv, naw; bit leak, tmo;
    @(negedge clk); m1.araddr = 32'h9000_0abc; m1.arvalid = 1;
    @(posedge clk); @(negedge clk); s.arready = 1;
    @(posedge clk); @(negedge clk); m1.arvalid = 0; s.arready = 0; s.rvalid = 1; s.rdata = 32'hdead_beef; #1;
    n_chk++; if ({m1.rvalid, m1.rdata} !== {1'b1, 32'hdead_beef})
      $display("FAIL rmid_pre: m1_rvalid=%b m1_rdata=%h exp 1/deadbeef", m1.rvalid, m1.rdata); else n_pass++;
    rst = 1; #1;
    n_chk++; if (dut_out() !== 21'd0) $display("FAIL rmid_async: outputs=%h exp 0", dut_out()); else n_pass++;
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if (dut_out() !== 21'd0) $display("FAIL rmid_hold: outputs=%h exp 0", dut_out()); else n_pass++;
    s.rvalid = 0; s.rdata = '0;
    @(negedge clk); rst = 0; m0.araddr = 32'h8000_0200; m0.arvalid = 1;
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if ({s.arvalid, s.araddr} !== {1'b1, 32'h8000_0200})
      $display("FAIL rmid_first_grant: s_arvalid=%b s_araddr=%h exp 1/80000200", s.arvalid, s.araddr); else n_pass++;
    serve(0, 0, 0, 0, 0, 32'h0bad_cafe, got, nrv, nbv, naw, leak, tmo);
    n_chk++; if ({tmo, leak, got} !== {2'b00, 32'h0bad_cafe})
      $display("FAIL rmid_m0_data: got=%h leak=%b tmo=%b exp 0badcafe", got, leak, tmo); else n_pass++;
  endtask

  // Random request mix; model keeps pending flags and who was served last
  task automatic test_random();
    bit p0, p1r, p1w, last, leak, tmo;
    int exp_g, obs_g, nrv, nbv, naw;
    logic [AW-1:0] a0, a1; logic [DW-1:0] wd, rd, got; logic [7:0] ws;
    apply_reset();
    p0 = 0; p1r = 0; p1w = 0; last = 1; a0 = '0; a1 = '0; wd = '0; ws = '0;
    for (int it = 0; it < 60; it++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; a0 = {4'h8, 28'($urandom)}; m0.araddr = a0; m0.arvalid = 1;
      end
      if (!p1r && !p1w && $urandom_range(0, 2) != 0) begin
        a1 = {4'h9, 28'($urandom)};
        if ($urandom_range(0, 2) == 0) begin
          p1w = 1; wd = $urandom; ws = 8'($urandom);
          m1.awaddr = a1; m1.awvalid = 1; m1.wdata = wd; m1.wstrb = ws; m1.wvalid = 1;
        end else begin
          p1r = 1; m1.araddr = a1; m1.arvalid = 1;
        end
      end
      #1;
      n_chk++; if ({s.arvalid, s.awvalid} !== 2'b00)
        $display("FAIL rnd_idle it%0d: s_arvalid=%b s_awvalid=%b exp 0/0", it, s.arvalid, s.awvalid); else n_pass++;
      if (!(p0 || p1r || p1w)) begin
        @(posedge clk); @(negedge clk);
        continue;
      end
      exp_g = p1w ? 2 : (p0 && p1r) ? (last ? 0 : 1) : (p0 ? 0 : 1);
      @(posedge clk); @(negedge clk); #1;
      obs_g = -1;
      if (s.awvalid && s.awaddr === a1 && s.wdata === wd && s.wstrb === ws) obs_g = 2;
      else if (s.arvalid && s.araddr === a0 && p0) obs_g = 0;
      else if (s.arvalid && s.araddr === a1 && p1r) obs_g = 1;
      n_chk++; if (obs_g != exp_g)
        $display("FAIL rnd_grant it%0d: granted=%0d exp %0d", it, obs_g, exp_g); else n_pass++;
      rd = $urandom;
      serve(exp_g != 0, exp_g == 2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            rd, got, nrv, nbv, naw, leak, tmo);
      if (exp_g == 2) begin
        n_chk++; if (tmo || leak || nbv != 1 || nrv != 0)
          $display("FAIL rnd_wr it%0d: bvalid_cnt=%0d rvalid_cnt=%0d leak=%b tmo=%b exp 1/0/0/0", it, nbv, nrv, leak, tmo); else n_pass++;
      end else begin
        n_chk++; if (tmo || leak || nbv != 0 || nrv != 1 || got !== rd)
          $display("FAIL rnd_rd it%0d: rdata=%h rvalid_cnt=%0d leak=%b tmo=%b exp %h/1/0/0", it, got, nrv, leak, tmo, rd); else n_pass++;
      end
      if (exp_g == 0) begin p0 = 0; last = 0; end
      else if (exp_g == 1) begin p1r = 0; last = 1; end
      else begin p1w = 0; last = 1; end
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_m0_read();
    test_tie();
    test_write_prio();
    test_aw_delay();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
